// File: rtl/dds_sine_period_meter.sv
// Rising-midscale-crossing period meter for the DDS sine lookup output.
// Hysteresis detector feeds a per-window period accumulator and peak/trough trackers;
// results publish once every 2^AVG_LOG2 periods with no gap between windows.
module dds_sine_period_meter #(
   parameter int unsigned DW       = 10,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned HYST     = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clr_i,
   input  logic                      sample_valid_i,
   input  logic [DW-1:0]             sample_i,
   output logic                      meas_valid_o,
   output logic [CNT_W+AVG_LOG2-1:0] period_sum_o,
   output logic [CNT_W-1:0]          period_avg_o,
   output logic [DW-1:0]             amp_max_o,
   output logic [DW-1:0]             amp_min_o,
   output logic                      locked_o,
   output logic                      timeout_o
);

   localparam int unsigned SW = CNT_W + AVG_LOG2;
   // Thresholds held one bit wider so MID+HYST cannot wrap for small DW.
   localparam logic [DW:0] ThHi = (DW+1)'((2 ** (DW - 1)) + HYST);
   localparam logic [DW:0] ThLo = (DW+1)'((2 ** (DW - 1)) - HYST);
   localparam logic [CNT_W-1:0]    CntMax  = '1;
   localparam logic [AVG_LOG2:0]   IdxLast = (AVG_LOG2+1)'((2 ** AVG_LOG2) - 1);

   typedef enum logic [0:0] {StSeekLow, StSeekHigh} state_e;

   state_e              state_q, state_d;
   logic                locked_q, locked_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [AVG_LOG2:0]   idx_q, idx_d;
   logic [SW-1:0]       sum_q, sum_d;
   logic [DW-1:0]       trk_max_q, trk_max_d;
   logic [DW-1:0]       trk_min_q, trk_min_d;
   logic                meas_valid_q, meas_valid_d;
   logic                timeout_q, timeout_d;
   logic [SW-1:0]       psum_q, psum_d;
   logic [CNT_W-1:0]    pavg_q, pavg_d;
   logic [DW-1:0]       amax_q, amax_d;
   logic [DW-1:0]       amin_q, amin_d;

   logic [DW:0]         samp_ext;
   logic                edge_hit;
   logic [SW-1:0]       period_len;
   logic [SW-1:0]       sum_next;
   logic [DW-1:0]       new_max;
   logic [DW-1:0]       new_min;

   assign samp_ext   = {1'b0, sample_i};
   assign edge_hit   = sample_valid_i && (state_q == StSeekHigh) && (samp_ext >= ThHi);
   assign period_len = SW'(cnt_q) + SW'(1);
   assign sum_next   = sum_q + period_len;
   assign new_max    = (sample_i > trk_max_q) ? sample_i : trk_max_q;
   assign new_min    = (sample_i < trk_min_q) ? sample_i : trk_min_q;

   // Crossing detector: arm below the low threshold, fire at or above the high one.
   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = StSeekLow;
      end else if (sample_valid_i) begin
         unique case (state_q)
            StSeekLow:  if (samp_ext <= ThLo) state_d = StSeekHigh;
            StSeekHigh: if (samp_ext >= ThHi) state_d = StSeekLow;
            default:    state_d = StSeekLow;
         endcase
      end
   end

   // Measurement control: lock, period accumulation, window close, timeout and clear.
   always_comb begin
      locked_d     = locked_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      sum_d        = sum_q;
      trk_max_d    = trk_max_q;
      trk_min_d    = trk_min_q;
      meas_valid_d = 1'b0;
      timeout_d    = 1'b0;
      psum_d       = psum_q;
      pavg_d       = pavg_q;
      amax_d       = amax_q;
      amin_d       = amin_q;
      if (clr_i) begin
         locked_d = 1'b0;
         cnt_d    = '0;
         idx_d    = '0;
         sum_d    = '0;
      end else if (sample_valid_i) begin
         if (!locked_q) begin
            if (edge_hit) begin
               locked_d  = 1'b1;
               cnt_d     = '0;
               idx_d     = '0;
               sum_d     = '0;
               trk_max_d = sample_i;
               trk_min_d = sample_i;
            end
         end else if (edge_hit) begin
            cnt_d = '0;
            if (idx_q == IdxLast) begin
               // Window closes on this edge; the next window opens on the same sample.
               meas_valid_d = 1'b1;
               psum_d       = sum_next;
               pavg_d       = CNT_W'(sum_next >> AVG_LOG2);
               amax_d       = new_max;
               amin_d       = new_min;
               sum_d        = '0;
               idx_d        = '0;
               trk_max_d    = sample_i;
               trk_min_d    = sample_i;
            end else begin
               sum_d     = sum_next;
               idx_d     = idx_q + 1'b1;
               trk_max_d = new_max;
               trk_min_d = new_min;
            end
         end else if (cnt_q == CntMax) begin
            // Lost the signal: drop lock and discard the partial window.
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
            idx_d     = '0;
            sum_d     = '0;
         end else begin
            cnt_d     = cnt_q + 1'b1;
            trk_max_d = new_max;
            trk_min_d = new_min;
         end
      end
   end

   // Detector state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StSeekLow;
      end else begin
         state_q <= state_d;
      end
   end

   // Measurement state and published results.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         locked_q     <= 1'b0;
         cnt_q        <= '0;
         idx_q        <= '0;
         sum_q        <= '0;
         trk_max_q    <= '0;
         trk_min_q    <= '0;
         meas_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         psum_q       <= '0;
         pavg_q       <= '0;
         amax_q       <= '0;
         amin_q       <= '0;
      end else begin
         locked_q     <= locked_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sum_q        <= sum_d;
         trk_max_q    <= trk_max_d;
         trk_min_q    <= trk_min_d;
         meas_valid_q <= meas_valid_d;
         timeout_q    <= timeout_d;
         psum_q       <= psum_d;
         pavg_q       <= pavg_d;
         amax_q       <= amax_d;
         amin_q       <= amin_d;
      end
   end

   assign meas_valid_o = meas_valid_q;
   assign period_sum_o = psum_q;
   assign period_avg_o = pavg_q;
   assign amp_max_o    = amax_q;
   assign amp_min_o    = amin_q;
   assign locked_o     = locked_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_dds_sine_period_meter.sv
// Directed bench for dds_sine_period_meter: square-ish pattern, dither, idle gaps,
// 64-sample sine, clr / reset mid-window and the no-crossing timeout.
module tb_dds_sine_period_meter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        valid = 1'b0;
   logic [9:0]  sample = '0;
   logic        meas_valid;
   logic [17:0] period_sum;
   logic [15:0] period_avg;
   logic [9:0]  amp_max;
   logic [9:0]  amp_min;
   logic        locked;
   logic        timeout;

   dds_sine_period_meter dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clr_i          (clr),
      .sample_valid_i (valid),
      .sample_i       (sample),
      .meas_valid_o   (meas_valid),
      .period_sum_o   (period_sum),
      .period_avg_o   (period_avg),
      .amp_max_o      (amp_max),
      .amp_min_o      (amp_min),
      .locked_o       (locked),
      .timeout_o      (timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int mv_cnt;
   int first_mv;
   int loc_idx;
   int idle_mv;
   int to_cnt;
   int pat[8]  = '{512, 700, 900, 700, 512, 300, 100, 300};
   int dith[8] = '{508, 700, 900, 515, 508, 300, 100, 515};
   int sine_tab[64];

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic scen_start();
      mv_cnt   = 0;
      first_mv = -1;
      loc_idx  = 0;
      idle_mv  = 0;
      to_cnt   = 0;
   endtask

   // One valid sample; outputs sampled 1 time unit after the accepting edge.
   task automatic put(input int v);
      @(negedge clk);
      valid  = 1'b1;
      sample = 10'(v);
      @(posedge clk);
      #1;
      if (meas_valid) begin
         if (mv_cnt == 0) first_mv = loc_idx;
         mv_cnt++;
      end
      if (timeout) to_cnt++;
      loc_idx++;
   endtask

   task automatic idle();
      @(negedge clk);
      valid = 1'b0;
      @(posedge clk);
      #1;
      if (meas_valid) idle_mv++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_mv"}, meas_valid, 0);
      check_eq({tag, "_sum"}, period_sum, 0);
      check_eq({tag, "_avg"}, period_avg, 0);
      check_eq({tag, "_max"}, amp_max, 0);
      check_eq({tag, "_min"}, amp_min, 0);
      check_eq({tag, "_locked"}, locked, 0);
      check_eq({tag, "_to"}, timeout, 0);
   endtask

   initial begin
      logic [7:0] phase;
      int         n;
      int         to_at;

      for (int k = 0; k < 64; k++) begin
         sine_tab[k] = $rtoi(512.0 + 400.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5);
      end

      // Reset state.
      #2;
      check_zero_outputs("rst");
      do_reset();

      // Basic pattern: lock at sample 9, windows close at 41 and 73.
      scen_start();
      for (int i = 0; i < 96; i++) put(pat[i % 8]);
      check_eq("pat_first_mv", first_mv, 41);
      check_eq("pat_mv_cnt", mv_cnt, 2);
      check_eq("pat_sum", period_sum, 32);
      check_eq("pat_avg", period_avg, 8);
      check_eq("pat_max", amp_max, 900);
      check_eq("pat_min", amp_min, 100);
      check_eq("pat_locked", locked, 1);
      check_eq("pat_to", to_cnt, 0);

      // clr mid-window: lock drops, outputs hold, re-acquire from scratch.
      @(negedge clk);
      valid = 1'b0;
      clr   = 1'b1;
      @(posedge clk);
      #1;
      check_eq("clr_locked", locked, 0);
      check_eq("clr_mv", meas_valid, 0);
      check_eq("clr_sum_held", period_sum, 32);
      check_eq("clr_max_held", amp_max, 900);
      check_eq("clr_min_held", amp_min, 100);
      @(negedge clk);
      clr = 1'b0;
      scen_start();
      for (int i = 0; i < 48; i++) put(pat[i % 8]);
      check_eq("clr_first_mv", first_mv, 41);
      check_eq("clr_mv_cnt", mv_cnt, 1);
      check_eq("clr_to", to_cnt, 0);

      // Reset mid-window: everything cleared, no partial publish.
      for (int i = 48; i < 68; i++) put(pat[i % 8]);
      @(negedge clk);
      valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("mrst");
      @(negedge clk);
      rst_n = 1'b1;
      scen_start();
      for (int i = 0; i < 48; i++) put(pat[i % 8]);
      check_eq("mrst_first_mv", first_mv, 41);
      check_eq("mrst_sum", period_sum, 32);

      // In-band dither must not create extra edges.
      do_reset();
      scen_start();
      for (int i = 0; i < 96; i++) put(dith[i % 8]);
      check_eq("dith_first_mv", first_mv, 41);
      check_eq("dith_mv_cnt", mv_cnt, 2);
      check_eq("dith_sum", period_sum, 32);
      check_eq("dith_avg", period_avg, 8);
      check_eq("dith_max", amp_max, 900);
      check_eq("dith_min", amp_min, 100);

      // Idle gaps between samples: identical results, single-cycle pulse.
      do_reset();
      scen_start();
      for (int i = 0; i < 96; i++) begin
         put(pat[i % 8]);
         repeat (3) idle();
      end
      check_eq("idle_first_mv", first_mv, 41);
      check_eq("idle_mv_cnt", mv_cnt, 2);
      check_eq("idle_mv_stuck", idle_mv, 0);
      check_eq("idle_sum", period_sum, 32);
      check_eq("idle_avg", period_avg, 8);
      check_eq("idle_max", amp_max, 900);
      check_eq("idle_min", amp_min, 100);

      // 64-sample DDS sine (tuning step 4 on an 8-bit phase): lock at 65, windows at 321, 577.
      do_reset();
      scen_start();
      phase = '0;
      for (int i = 0; i < 640; i++) begin
         put(sine_tab[phase[7:2]]);
         phase = phase + 8'd4;
      end
      check_eq("sine_first_mv", first_mv, 321);
      check_eq("sine_mv_cnt", mv_cnt, 2);
      check_eq("sine_sum", period_sum, 256);
      check_eq("sine_avg", period_avg, 64);
      check_eq("sine_max", amp_max, 912);
      check_eq("sine_min", amp_min, 112);

      // Timeout: lock, then hold midscale; fires on the 65536th post-lock sample.
      do_reset();
      scen_start();
      for (int i = 0; i < 10; i++) put(pat[i % 8]);
      check_eq("to_locked_pre", locked, 1);
      to_at = -1;
      n = 0;
      while (n < 70000 && to_at < 0) begin
         put(512);
         n++;
         if (to_cnt != 0) begin
            to_at = n;
            check_eq("to_locked_post", locked, 0);
         end
      end
      check_eq("to_at", to_at, 65536);
      idle();
      check_eq("to_single_cycle", timeout, 0);
      check_eq("to_no_mv", mv_cnt, 0);
      scen_start();
      for (int i = 0; i < 48; i++) put(pat[i % 8]);
      check_eq("to_relock_first_mv", first_mv, 41);
      check_eq("to_relock_sum", period_sum, 32);
      check_eq("to_relock_locked", locked, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
